vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing generator for the 640x480 VGA display path. Divides the system clock down to the pixel rate and runs horizontal and vertical scan counters. Produces hsync/vsync, video_on and the pixel_x/pixel_y coordinates consumed by the pixel generation logic. Registers the pixel generator's rgb back out to the monitor with blanking applied, aligned to the sync outputs.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; legal range 1..16
- SYNC_ACTIVE, 0, active level of hsync and vsync (0 means active-low)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- rgb_in  in  3  pixel colour from the pixel generator for the current pixel_x/pixel_y
- p_tick  out  1  pixel-rate enable
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  current count is inside the visible area
- frame_tick  out  1  one-clk pulse on the last pixel of each frame
- hsync  out  1  horizontal sync to the monitor, registered
- vsync  out  1  vertical sync to the monitor, registered
- rgb_out  out  3  colour to the monitor, registered, forced to 0 while blanking

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800 by default). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525 by default).
- Divider: div_cnt counts 0..CLK_DIV-1 each clk and wraps to 0.
  - p_tick = (div_cnt == CLK_DIV-1), combinational from the register.
  - When CLK_DIV=1, p_tick is constantly 1 (including during reset).
- Horizontal counter: on a clk edge with p_tick=1, h_cnt increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: increments on the same edge where h_cnt wraps. At V_TOTAL-1 it wraps to 0, so both counters wrap simultaneously at the frame end.
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the registers. Coordinates are unsigned and never exceed H_TOTAL-1 / V_TOTAL-1.
- video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY), combinational.
- frame_tick = p_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1, combinational.
- Sync decode ranges:
  - hsync is active for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751 by default.
  - vsync is active for v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491 by default.
  - Active means driven to SYNC_ACTIVE; otherwise the output is ~SYNC_ACTIVE.
- Output stage, updated every clk (not gated by p_tick):
  - hsync <= decoded hsync of the current counters.
  - vsync <= decoded vsync of the current counters.
  - rgb_out <= video_on ? rgb_in : 3'b000.
- The vertical count passes through line 481 at pixel 0 in every frame, so refresh-tick logic keyed on (481, 0) fires exactly once per frame.

## Timing
- Reset values, visible the clk after a sampled rst=1:
  - div_cnt, h_cnt, v_cnt = 0, so pixel_x = pixel_y = 0.
  - p_tick = 0 when CLK_DIV>1.
  - video_on = 1 (counters at 0,0).
  - frame_tick = 0.
  - hsync = vsync = ~SYNC_ACTIVE.
  - rgb_out = 0.
- rst asserted mid-frame restarts the frame at 0,0 on the next edge. No partial sync pulse survives: the registered hsync/vsync go inactive on that edge.
- Pixel period is exactly CLK_DIV clks. A line is H_TOTAL*CLK_DIV clks; a frame is H_TOTAL*V_TOTAL*CLK_DIV clks.
- Counter value n = v*H_TOTAL+h is reached CLK_DIV*n edges after reset release.
- hsync, vsync and rgb_out lag the counters by exactly one clk. pixel_x, pixel_y, video_on, p_tick and frame_tick have zero latency relative to the counters.
- rgb_in is sampled every clk. The pixel generator must hold rgb_in valid for the whole pixel period, since it is a combinational function of pixel_x/pixel_y.
- frame_tick is high for exactly one clk per frame. The edge that ends that clk wraps both counters to 0.

## Test plan
- Reset, defaults: hold rst 3 clks, release.
  - Expect pixel_x=0, pixel_y=0, hsync=1, vsync=1, rgb_out=0, p_tick=0.
  - Expect p_tick high on clks 1, 3, 5, ... after release.
- Line timing, defaults: measure hsync.
  - Expect it low for 192 clks, first low one clk after pixel_x becomes 656.
  - Expect a line period of 1600 clks.
  - Expect video_on high for pixel_x 0..639 only.
- Frame timing, defaults:
  - Expect vsync low for 2 lines (3200 clks), starting one clk after pixel_y=490, pixel_x=0.
  - Expect frame_tick exactly once, 839999 edges after release.
  - Expect pixel_x=pixel_y=0 after edge 840000.
  - Expect (pixel_x,pixel_y)=(0,481) visited once per frame.
- Blanking, rgb_in held at 3'b110:
  - Expect rgb_out=110 one clk after video_on rises.
  - Expect rgb_out=000 from one clk after pixel_x=640 until the next visible pixel, and across all lines 480..524.
- Mid-frame reset: assert rst for 1 clk at pixel_x=700, pixel_y=490 (hsync and vsync active).
  - Expect counters 0,0 and hsync=vsync=1 on the next edge.
  - Expect the next frame_tick 839999 edges after release.
- CLK_DIV=1, SYNC_ACTIVE=1:
  - Expect p_tick constantly 1 and a line period of 800 clks.
  - Expect hsync high for 96 clks and vsync high for 1600 clks.
  - Expect a frame of 420000 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing generator: pixel-rate divider, horizontal/vertical scan
// counters, sync decode and a registered, blanked colour output stage.
module vga_sync_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int CLK_DIV     = 2,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rgb_in,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic       SYNC_OFF = ~SYNC_ON;

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_end;
    logic             v_end;
    logic             h_sync_act;
    logic             v_sync_act;

    // With CLK_DIV=1 DIV_LAST is 0 and div_cnt never leaves 0, so p_tick stays high.
    assign p_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (p_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;
    assign video_on   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_tick = p_tick && h_end && v_end;

    assign h_sync_act = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign v_sync_act = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    // Output stage runs every clk so sync and colour trail the counters by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync   <= SYNC_OFF;
            vsync   <= SYNC_OFF;
            rgb_out <= '0;
        end else begin
            hsync   <= h_sync_act ? SYNC_ON : SYNC_OFF;
            vsync   <= v_sync_act ? SYNC_ON : SYNC_OFF;
            rgb_out <= video_on ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing over a few lines, plus two reduced
// geometries (CLK_DIV=2 active-low, CLK_DIV=1 active-high) over whole frames.
module tb_vga_sync_gen;

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb, dv, act;
    } geom_t;

    typedef struct {
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } reg_exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    logic [2:0] rgbi [3] = '{3'b110, 3'b110, 3'b110};
    logic [2:0] p_tick_w, video_on_w, frame_tick_w, hsync_w, vsync_w;
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic [2:0] rgbo [3];

    int       n [3];
    reg_exp_t sbq [3][$];
    int       n_checks = 0;
    int       n_fail = 0;
    int       visits = 0;
    bit       at_vis = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen dut0 (
        .clk(clk), .rst(rst_v[0]), .rgb_in(rgbi[0]), .p_tick(p_tick_w[0]),
        .pixel_x(px[0]), .pixel_y(py[0]), .video_on(video_on_w[0]),
        .frame_tick(frame_tick_w[0]), .hsync(hsync_w[0]), .vsync(vsync_w[0]),
        .rgb_out(rgbo[0])
    );

    vga_sync_gen #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(3), .V_SYNC(2), .V_BACK(5),
        .CLK_DIV(2), .SYNC_ACTIVE(0)
    ) dut1 (
        .clk(clk), .rst(rst_v[1]), .rgb_in(rgbi[1]), .p_tick(p_tick_w[1]),
        .pixel_x(px[1]), .pixel_y(py[1]), .video_on(video_on_w[1]),
        .frame_tick(frame_tick_w[1]), .hsync(hsync_w[1]), .vsync(vsync_w[1]),
        .rgb_out(rgbo[1])
    );

    vga_sync_gen #(
        .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_DISPLAY(48), .V_FRONT(3), .V_SYNC(2), .V_BACK(5),
        .CLK_DIV(1), .SYNC_ACTIVE(1)
    ) dut2 (
        .clk(clk), .rst(rst_v[2]), .rgb_in(rgbi[2]), .p_tick(p_tick_w[2]),
        .pixel_x(px[2]), .pixel_y(py[2]), .video_on(video_on_w[2]),
        .frame_tick(frame_tick_w[2]), .hsync(hsync_w[2]), .vsync(vsync_w[2]),
        .rgb_out(rgbo[2])
    );

    function automatic geom_t geom(input int i);
        geom_t g;
        if (i == 0)      g = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0};
        else if (i == 1) g = '{64, 4, 8, 4, 48, 3, 2, 5, 2, 0};
        else             g = '{64, 4, 8, 4, 48, 3, 2, 5, 1, 1};
        return g;
    endfunction

    // Position reached k edges after reset release, derived from the edge count.
    task automatic pos(input int i, input int k, output int h, output int v, output int d);
        geom_t g;
        int    ht, vt;
        g  = geom(i);
        ht = g.hd + g.hf + g.hs + g.hb;
        vt = g.vd + g.vf + g.vs + g.vb;
        d  = k % g.dv;
        h  = (k / g.dv) % ht;
        v  = (k / g.dv / ht) % vt;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) n[i] <= rst_v[i] ? 0 : n[i] + 1;
    end

    // Expected registered outputs for this edge, from pre-edge model state and inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            geom_t    g;
            reg_exp_t e;
            int       h, v, d;
            logic     on;
            g  = geom(i);
            on = (g.act != 0);
            pos(i, n[i], h, v, d);
            if (rst_v[i]) begin
                e = '{~on, ~on, 3'b000};
            end else begin
                e.hs  = (h >= g.hd + g.hf && h < g.hd + g.hf + g.hs) ? on : ~on;
                e.vs  = (v >= g.vd + g.vf && v < g.vd + g.vf + g.vs) ? on : ~on;
                e.rgb = (h < g.hd && v < g.vd) ? rgbi[i] : 3'b000;
            end
            sbq[i].push_back(e);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            geom_t    g;
            reg_exp_t e;
            int       h, v, d, ht, vt;
            logic     pt;
            g  = geom(i);
            ht = g.hd + g.hf + g.hs + g.hb;
            vt = g.vd + g.vf + g.vs + g.vb;
            pos(i, n[i], h, v, d);
            pt = (d == g.dv - 1);
            check($sformatf("d%0d pixel_x", i), 32'(px[i]), h);
            check($sformatf("d%0d pixel_y", i), 32'(py[i]), v);
            check($sformatf("d%0d p_tick", i), 32'(p_tick_w[i]), 32'(pt));
            check($sformatf("d%0d video_on", i), 32'(video_on_w[i]), 32'(h < g.hd && v < g.vd));
            check($sformatf("d%0d frame_tick", i), 32'(frame_tick_w[i]),
                  32'(pt && h == ht - 1 && v == vt - 1));
            if (sbq[i].size() > 0) begin
                e = sbq[i].pop_front();
                check($sformatf("d%0d hsync", i), 32'(hsync_w[i]), 32'(e.hs));
                check($sformatf("d%0d vsync", i), 32'(vsync_w[i]), 32'(e.vs));
                check($sformatf("d%0d rgb_out", i), 32'(rgbo[i]), 32'(e.rgb));
            end
            if (i == 1) begin
                if (px[1] == 10'd0 && py[1] == 10'd49 && !at_vis) visits++;
                at_vis = (px[1] == 10'd0 && py[1] == 10'd49);
            end
            if (i == 0) rgbi[0] = 3'b110;
            else        rgbi[i] = 3'($urandom_range(0, 7));
        end
    end

    task automatic wait_for(input int which, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            case (which)
                0:  ok = (px[0] == 10'd656);
                1:  ok = (hsync_w[0] == 1'b0);
                2:  ok = (hsync_w[0] == 1'b1);
                3:  ok = (px[1] == 10'd0 && py[1] == 10'd51);
                4:  ok = (vsync_w[1] == 1'b0);
                5:  ok = (vsync_w[1] == 1'b1);
                6:  ok = (frame_tick_w[1] == 1'b1);
                7:  ok = (px[1] == 10'd70 && py[1] == 10'd51);
                8:  ok = (hsync_w[2] == 1'b1);
                9:  ok = (hsync_w[2] == 1'b0);
                10: ok = (vsync_w[2] == 1'b1);
                11: ok = (vsync_w[2] == 1'b0);
                default: ok = (frame_tick_w[2] == 1'b1);
            endcase
        end
        check($sformatf("wait%0d reached", which), 32'(ok), 32'd1);
    endtask

    initial begin
        int a0, b0, a1, b1, v0, a2;
        repeat (3) @(negedge clk);
        check("rst pixel_x", 32'(px[0]), 32'd0);
        check("rst pixel_y", 32'(py[0]), 32'd0);
        check("rst hsync", 32'(hsync_w[0]), 32'd1);
        check("rst vsync", 32'(vsync_w[0]), 32'd1);
        check("rst rgb_out", 32'(rgbo[0]), 32'd0);
        check("rst p_tick", 32'(p_tick_w[0]), 32'd0);
        check("rst video_on", 32'(video_on_w[0]), 32'd1);
        check("rst frame_tick", 32'(frame_tick_w[0]), 32'd0);
        check("rst p_tick div1", 32'(p_tick_w[2]), 32'd1);
        check("rst hsync act-high", 32'(hsync_w[2]), 32'd0);
        rst_v = 3'b000;
        v0 = visits;
        fork
            begin
                wait_for(0, 5000);
                a0 = n[0];
                wait_for(1, 10);
                check("d0 hsync start", n[0] - a0, 32'd1);
                b0 = n[0];
                wait_for(2, 400);
                check("d0 hsync width", n[0] - b0, 32'd192);
                wait_for(1, 2000);
                check("d0 line period", n[0] - b0, 32'd1600);
            end
            begin
                wait_for(3, 20000);
                a1 = n[1];
                wait_for(4, 10);
                check("d1 vsync start", n[1] - a1, 32'd1);
                b1 = n[1];
                wait_for(5, 1000);
                check("d1 vsync width", n[1] - b1, 32'd320);
                wait_for(6, 2000);
                check("d1 frame_tick edge", n[1], 32'd9279);
                @(negedge clk);
                check("d1 wrap pixel_x", 32'(px[1]), 32'd0);
                check("d1 wrap pixel_y", 32'(py[1]), 32'd0);
                check("d1 refresh visits", visits - v0, 32'd1);
                wait_for(7, 20000);
                check("d1 pre-rst hsync", 32'(hsync_w[1]), 32'd0);
                check("d1 pre-rst vsync", 32'(vsync_w[1]), 32'd0);
                rst_v[1] = 1'b1;
                @(negedge clk);
                check("d1 mid-rst pixel_x", 32'(px[1]), 32'd0);
                check("d1 mid-rst pixel_y", 32'(py[1]), 32'd0);
                check("d1 mid-rst hsync", 32'(hsync_w[1]), 32'd1);
                check("d1 mid-rst vsync", 32'(vsync_w[1]), 32'd1);
                rst_v[1] = 1'b0;
                wait_for(6, 12000);
                check("d1 frame_tick after rst", n[1], 32'd9279);
            end
            begin
                wait_for(8, 200);
                a2 = n[2];
                wait_for(9, 20);
                check("d2 hsync width", n[2] - a2, 32'd8);
                wait_for(8, 200);
                check("d2 line period", n[2] - a2, 32'd80);
                wait_for(10, 5000);
                a2 = n[2];
                check("d2 vsync start", a2, 32'd4081);
                wait_for(11, 400);
                check("d2 vsync width", n[2] - a2, 32'd160);
                wait_for(12, 1000);
                check("d2 first frame_tick", n[2], 32'd4639);
                wait_for(12, 6000);
                check("d2 second frame_tick", n[2], 32'd9279);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
